// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS main controller.
//   - state encodings (state_t)
//   - opcode / func constants
//   - alu_op, alu_src_b and pc_source encodings
//   - ctrl_t bundle of control outputs and state_ctrl(), the Moore
//     output decode for each state
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] FUNC_MULT = 6'b100001;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Control word for a given state; unlisted encodings give all zeros.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_OP_ADD;
                c.pc_source = PC_SRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH;
                c.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_OP_RTYPE;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRC_B_REG;
                c.alu_op        = ALU_OP_SUB;
                c.pc_source     = PC_SRC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_exec_stretch.sv
// mc_exec_stretch: loadable down-counter holding the EXECUTE state.
//   clk, reset : clock, synchronous active-high reset (clears count)
//   load       : load load_val (takes priority over dec)
//   load_val   : remaining extra EXECUTE cycles
//   dec        : decrement by one, saturating at zero
//   done       : count is zero
module mc_exec_stretch #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle main controller for the non-pipelined MIPS
// datapath (FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE,
// R_WB, BRANCH, JUMP).
//
// Optional build macro MC_MEM_WAIT_EN: adds input mem_ready; FETCH,
// MEM_READ and MEM_WRITE hold until mem_ready = 1, and the FETCH
// pc_write/ir_write strobes fire only in the mem_ready cycle.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   opcode, func       instruction fields (func only for multiply stretch)
//   zero               ALU zero flag (qualification of pc_write_cond is external)
//   mem_ready          memory handshake (MC_MEM_WAIT_EN only)
//   pc_write .. pc_source  registered Moore control outputs
//   state              current state encoding
//   illegal_op         one-cycle pulse after DECODE sees an unsupported opcode
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_nx;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   illegal_nx;
    // Low for the cycle after reset: the FSM re-enters FETCH with its
    // strobes so the reset cycle itself never drives a strobe.
    logic   live_q;
    logic   cnt_load;
    logic   cnt_done;
    logic   mem_rdy;

    // pc_write_cond is combined with zero in the datapath, not here.
    logic   unused_zero;
    assign unused_zero = zero;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign cnt_load = (state_q == S_DECODE) && (opcode == OP_RTYPE);

    mc_exec_stretch #(
        .CNT_W (CNT_W)
    ) u_stretch (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val ((func == FUNC_MULT) ? CNT_W'(MULT_CYCLES - 1) : '0),
        .dec      (state_q == S_EXECUTE),
        .done     (cnt_done)
    );

    always_comb begin
        state_nx   = S_FETCH;
        illegal_nx = 1'b0;
        if (live_q) begin
            case (state_q)
                S_FETCH:     state_nx = mem_rdy ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_nx = S_MEM_ADDR;
                        OP_RTYPE:     state_nx = S_EXECUTE;
                        OP_BEQ:       state_nx = S_BRANCH;
                        OP_J:         state_nx = S_JUMP;
                        default: begin
                            state_nx   = S_FETCH;
                            illegal_nx = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR:  state_nx = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  state_nx = mem_rdy ? S_MEM_WB : S_MEM_READ;
                S_MEM_WRITE: state_nx = mem_rdy ? S_FETCH : S_MEM_WRITE;
                S_EXECUTE:   state_nx = cnt_done ? S_R_WB : S_EXECUTE;
                default:     state_nx = S_FETCH;
            endcase
        end
    end

    // Outputs are loaded from the decode of the next state so they line up
    // with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            ctrl_q    <= state_ctrl(state_nx);
            illegal_q <= illegal_nx;
            live_q    <= 1'b1;
        end
    end

`ifdef MC_MEM_WAIT_EN
    assign pc_write = ctrl_q.pc_write & ((state_q != S_FETCH) | mem_ready);
    assign ir_write = ctrl_q.ir_write & ((state_q != S_FETCH) | mem_ready);
`else
    assign pc_write = ctrl_q.pc_write;
    assign ir_write = ctrl_q.ir_write;
`endif

    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_source     = ctrl_q.pc_source;
    assign state         = state_q;
    assign illegal_op    = illegal_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller for the non-pipelined MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit alu_op consumed by the ALU control decoder, plus all register-file, memory, PC and mux selects.
- Stretches the execute phase for multi-cycle multiply (func 6'b100001) using an internal counter.

Parameters:
- MULT_CYCLES, 4, number of EXECUTE cycles held for a multiply R-type (legal range 1..15).
- CNT_W, 4, width of the execute-stretch counter.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- opcode  input  6  instruction[31:26], valid from DECODE onward
- func  input  6  instruction[5:0], used only for the multiply stretch
- zero  input  1  ALU zero flag, sampled in BRANCH
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by zero (beq)
- i_or_d  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback data select, 1 = MDR
- reg_dst  output  1  1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  output  2  00 = add, 01 = beq subtract, 10 = R-type (func decode)
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding, for debug
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- Outputs are a Moore function of state only; all are registered through the state register. No output depends combinationally on opcode/func/zero, except pc_write_cond gating, which is done externally.
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXECUTE = 6, R_WB = 7, BRANCH = 8, JUMP = 9
- Reset:
  - state = FETCH, counter = 0, illegal_op = 0.
  - All strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are 0 during the reset cycle.
  - Reset asserted in any state aborts the instruction; no write strobe is asserted in the cycle after reset is sampled.
- FETCH:
  - mem_read = 1, ir_write = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00, pc_write = 1.
  - Next state: DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - else -> FETCH with illegal_op = 1 for exactly one cycle.
- MEM_ADDR:
  - alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, i_or_d = 1 -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0 -> FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1 -> FETCH.
- EXECUTE:
  - alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - Non-multiply: one cycle, then R_WB.
  - func = 100001: counter loads MULT_CYCLES-1 on entry and decrements each cycle; leaves for R_WB when counter = 0. EXECUTE is occupied exactly MULT_CYCLES cycles.
  - MULT_CYCLES = 1 behaves as non-multiply.
- R_WB: reg_write = 1, mem_to_reg = 0, reg_dst = 1 -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, pc_write_cond = 1 -> FETCH.
- JUMP: pc_write = 1, pc_source = 10 -> FETCH.
- Unused encodings 10..15 -> FETCH next cycle, all strobes 0.
- Instruction latencies (FETCH to FETCH):
  - lw 5 cycles, sw 4, R-type 4, mult 3+MULT_CYCLES, beq 3, j 3.

Optional Feature:
- Macro: MC_MEM_WAIT_EN
- Defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEM_READ and MEM_WRITE hold their state and keep strobes asserted until mem_ready = 1.
  - pc_write and ir_write in FETCH are asserted only in the cycle mem_ready = 1.
- Undefined: no port is added; memory is assumed single-cycle and behaviour is exactly as above.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
  - FUNC_MULT
  - ALU_OP_ADD, ALU_OP_SUB, ALU_OP_RTYPE
  - alu_src_b and pc_source encodings
- One sub-module, mc_exec_stretch: the loadable down-counter with a done flag, instantiated for the multiply stretch.

Test Plan:
- reset held 2 cycles, released -> state = 0, mem_read = 1, ir_write = 1, pc_write = 1 in the first cycle after release.
- lw (opcode 100011) -> state trace 0,1,2,3,4,0; reg_write = 1 with mem_to_reg = 1 only in state 4.
- add R-type (func 100000) then mult (func 100001), MULT_CYCLES = 4 -> EXECUTE held 1 and 4 cycles respectively; alu_op = 10 throughout.
- beq with zero = 1 and zero = 0 -> state trace 0,1,8,0; pc_write_cond = 1, alu_op = 01, pc_source = 01 in state 8.
- opcode 111111 -> state 0,1,0; illegal_op pulses high one cycle; no write strobe asserted.
- reset asserted in MEM_WRITE and in EXECUTE mid-multiply -> next state FETCH, mem_write = 0, counter cleared; with MC_MEM_WAIT_EN, mem_ready held 0 for 3 cycles -> FETCH held 3 extra cycles.
